// File: rtl/rdma_stream_pkg.sv
// Shared types and constant helpers for the RDMA stream segmenter/reassembler pair.
package rdma_stream_pkg;

    localparam int DEFAULT_MTU        = 64;
    localparam int DEFAULT_FRAME_SIZE = 128;

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int lcm(input int a, input int b);
        return (a / gcd(a, b)) * b;
    endfunction

    function automatic int ratio(input int frame_size, input int mtu);
        return (mtu > 0) ? frame_size / mtu : 1;
    endfunction

    localparam int DEFAULT_RATIO = ratio(DEFAULT_FRAME_SIZE, DEFAULT_MTU);

    // Sized for the default MTU/frame pairing; other pairings size their own counters.
    typedef logic [((DEFAULT_RATIO > 1) ? $clog2(DEFAULT_RATIO) : 1)-1:0] lane_idx_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_FILL = 1'b1
    } acc_state_e;

endpackage

// File: rtl/axis_hold_reg.sv
// Single-entry AXI-Stream output register: holds a frame until accepted,
// and drives all payload fields to zero while empty.
module axis_hold_reg
    import rdma_stream_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int KEEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last
);

    out_state_e        state_reg, state_next;
    logic [DATA_W-1:0] data_reg;
    logic [KEEP_W-1:0] keep_reg;
    logic              last_reg;

    // The producer only loads when empty or when the held frame leaves this cycle.
    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = OUT_FULL;
        end else if (state_reg == OUT_FULL && out_ready) begin
            state_next = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= OUT_EMPTY;
            data_reg  <= '0;
            keep_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                data_reg <= load_data;
                keep_reg <= load_keep;
                last_reg <= load_last;
            end
        end
    end

    assign out_valid = (state_reg == OUT_FULL);
    assign out_data  = out_valid ? data_reg : '0;
    assign out_keep  = out_valid ? keep_reg : '0;
    assign out_last  = out_valid && last_reg;

endmodule

// File: rtl/packet_reassembler.sv
// Gathers MTU-wide beats into AXI_FRAME_SIZE-wide frames, closing on a full frame or tlast.
// Optional frame/packet counters are enabled by RDMA_REASSEMBLER_STATS_EN.
module packet_reassembler
    import rdma_stream_pkg::*;
#(
    parameter int MTU            = 64,
    parameter int AXI_FRAME_SIZE = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MTU-1:0]               s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [AXI_FRAME_SIZE-1:0]    m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [AXI_FRAME_SIZE/MTU-1:0] m_axis_tkeep
`ifdef RDMA_REASSEMBLER_STATS_EN
    ,
    output logic [31:0]                  stat_frames,
    output logic [31:0]                  stat_packets
`endif
);

    localparam int RATIO  = ratio(AXI_FRAME_SIZE, MTU);
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (AXI_FRAME_SIZE % MTU != 0) begin : g_bad_ratio
        $warning("packet_reassembler: AXI_FRAME_SIZE is not a multiple of MTU");
    end

    if (RATIO == 1) begin : g_bypass
        assign m_axis_tdata  = s_axis_tdata;
        assign m_axis_tvalid = s_axis_tvalid;
        assign m_axis_tlast  = s_axis_tlast;
        assign m_axis_tkeep  = '1;
        assign s_axis_tready = m_axis_tready;
    end else begin : g_acc
        acc_state_e                acc_state_reg, acc_state_next;
        logic [LANE_W-1:0]         lane_cnt_reg, lane_cnt_next;
        logic [AXI_FRAME_SIZE-1:0] frame_data;
        logic [RATIO-1:0]          frame_keep;
        logic                      accept;
        logic                      close;

        assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
        assign accept        = s_axis_tvalid && s_axis_tready;
        assign close         = accept && ((lane_cnt_reg == LANE_W'(RATIO - 1)) || s_axis_tlast);

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_state_reg <= ACC_IDLE;
                lane_cnt_reg  <= '0;
            end else begin
                acc_state_reg <= acc_state_next;
                lane_cnt_reg  <= lane_cnt_next;
            end
        end

        always_comb begin
            acc_state_next = acc_state_reg;
            lane_cnt_next  = lane_cnt_reg;
            case (acc_state_reg)
                ACC_IDLE: begin
                    if (accept && !close) begin
                        acc_state_next = ACC_FILL;
                        lane_cnt_next  = lane_cnt_reg + LANE_W'(1);
                    end
                end
                ACC_FILL: begin
                    if (close) begin
                        acc_state_next = ACC_IDLE;
                        lane_cnt_next  = '0;
                    end else if (accept) begin
                        lane_cnt_next = lane_cnt_reg + LANE_W'(1);
                    end
                end
                default: begin
                    acc_state_next = ACC_IDLE;
                    lane_cnt_next  = '0;
                end
            endcase
        end

        // Lanes are cleared on close, so unwritten upper lanes of a short frame read as zero.
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            logic [MTU-1:0] lane_reg;
            logic           lane_sel;

            assign lane_sel = (lane_cnt_reg == LANE_W'(gi));

            always_ff @(posedge clk) begin
                if (rst || close) begin
                    lane_reg <= '0;
                end else if (accept && lane_sel) begin
                    lane_reg <= s_axis_tdata;
                end
            end

            assign frame_data[gi*MTU +: MTU] = lane_sel ? s_axis_tdata : lane_reg;

            if (gi == 0) begin : g_keep0
                assign frame_keep[gi] = 1'b1;
            end else begin : g_keepn
                assign frame_keep[gi] = (lane_cnt_reg >= LANE_W'(gi));
            end
        end

        axis_hold_reg #(
            .DATA_W (AXI_FRAME_SIZE),
            .KEEP_W (RATIO)
        ) u_hold (
            .clk       (clk),
            .rst       (rst),
            .load      (close),
            .load_data (frame_data),
            .load_keep (frame_keep),
            .load_last (s_axis_tlast),
            .out_ready (m_axis_tready),
            .out_valid (m_axis_tvalid),
            .out_data  (m_axis_tdata),
            .out_keep  (m_axis_tkeep),
            .out_last  (m_axis_tlast)
        );
    end

`ifdef RDMA_REASSEMBLER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames  <= '0;
            stat_packets <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            stat_frames <= stat_frames + 32'd1;
            if (m_axis_tlast) begin
                stat_packets <= stat_packets + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_reassembler.sv
// Scoreboard bench for packet_reassembler in 64/128, 32/128 and 128/128 (bypass) configurations.
module tb_packet_reassembler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [63:0]  s0_data;
    logic         s0_valid, s0_ready, s0_last;
    logic [127:0] m0_data;
    logic         m0_valid, m0_ready, m0_last;
    logic [1:0]   m0_keep;

    logic [31:0]  s1_data;
    logic         s1_valid, s1_ready, s1_last;
    logic [127:0] m1_data;
    logic         m1_valid, m1_ready, m1_last;
    logic [3:0]   m1_keep;

    logic [127:0] s2_data;
    logic         s2_valid, s2_ready, s2_last;
    logic [127:0] m2_data;
    logic         m2_valid, m2_ready, m2_last;
    logic [0:0]   m2_keep;

    packet_reassembler #(.MTU(64), .AXI_FRAME_SIZE(128)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s0_data), .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready), .s_axis_tlast(s0_last),
        .m_axis_tdata(m0_data), .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready), .m_axis_tlast(m0_last),
        .m_axis_tkeep(m0_keep)
    );

    packet_reassembler #(.MTU(32), .AXI_FRAME_SIZE(128)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready), .s_axis_tlast(s1_last),
        .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tlast(m1_last),
        .m_axis_tkeep(m1_keep)
    );

    packet_reassembler #(.MTU(128), .AXI_FRAME_SIZE(128)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s2_data), .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready), .s_axis_tlast(s2_last),
        .m_axis_tdata(m2_data), .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready), .m_axis_tlast(m2_last),
        .m_axis_tkeep(m2_keep)
    );

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [127:0] d, input logic [3:0] k, input logic l);
        frame_t f;
        f.data = d;
        f.keep = k;
        f.last = l;
        q0.push_back(f);
    endtask

    task automatic push1(input logic [127:0] d, input logic [3:0] k, input logic l);
        frame_t f;
        f.data = d;
        f.keep = k;
        f.last = l;
        q1.push_back(f);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
    task automatic send0(input logic [63:0] d, input logic l);
        bit rdy;
        s0_data  = d;
        s0_last  = l;
        s0_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = s0_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL d0_send_timeout: got no ready expected ready within 50 cycles");
    endtask

    task automatic send1(input logic [31:0] d, input logic l);
        bit rdy;
        s1_data  = d;
        s1_last  = l;
        s1_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = s1_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL d1_send_timeout: got no ready expected ready within 50 cycles");
    endtask

    always @(negedge clk) begin
        if (!rst && m0_valid && m0_ready) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL d0_unexpected: got %h expected no frame", m0_data);
            end else begin : pop0
                frame_t e;
                e = q0.pop_front();
                $display("d0 frame data=%h keep=%b last=%b", m0_data, m0_keep, m0_last);
                chk("d0_data", m0_data, e.data);
                chk("d0_keep", m0_keep, e.keep);
                chk("d0_last", m0_last, e.last);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m1_valid && m1_ready) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL d1_unexpected: got %h expected no frame", m1_data);
            end else begin : pop1
                frame_t e;
                e = q1.pop_front();
                $display("d1 frame data=%h keep=%b last=%b", m1_data, m1_keep, m1_last);
                chk("d1_data", m1_data, e.data);
                chk("d1_keep", m1_keep, e.keep);
                chk("d1_last", m1_last, e.last);
            end
        end
    end

    initial begin : main
        int t0;
        s0_data = '0; s0_valid = 1'b0; s0_last = 1'b0; m0_ready = 1'b1;
        s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0; m1_ready = 1'b1;
        s2_data = '0; s2_valid = 1'b0; s2_last = 1'b0; m2_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", m0_valid, 1'b0);
        chk("rst_data",  m0_data,  128'h0);
        chk("rst_keep",  m0_keep,  2'b00);
        chk("rst_last",  m0_last,  1'b0);
        chk("rst_ready", s0_ready, 1'b1);
        chk("rst_valid1", m1_valid, 1'b0);

        // Two-beat packet, one-cycle latency.
        push0({64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}, 4'b0011, 1'b1);
        send0(64'hA0A0_0000_0000_0000, 1'b0);
        send0(64'hA1A1_0000_0000_0001, 1'b1);
        chk("d0_latency", m0_valid, 1'b1);
        s0_valid = 1'b0;

        // Single-beat packet, then a new frame starting in lane 0.
        push0({64'h0, 64'hB0B0_B0B0_0000_0000}, 4'b0001, 1'b1);
        send0(64'hB0B0_B0B0_0000_0000, 1'b1);
        push0({64'hC1C1_0000_1111_0000, 64'hC0C0_0000_0000_2222}, 4'b0011, 1'b1);
        send0(64'hC0C0_0000_0000_2222, 1'b0);
        send0(64'hC1C1_0000_1111_0000, 1'b1);
        s0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", m0_valid, 1'b0);
        chk("idle_data",  m0_data,  128'h0);
        chk("idle_keep",  m0_keep,  2'b00);
        chk("idle_last",  m0_last,  1'b0);

        // Consecutive single-beat packets: consume and reload in the same cycle.
        push0({64'h0, 64'h6000_0000_0000_0000}, 4'b0001, 1'b1);
        push0({64'h0, 64'h6000_0000_0000_0001}, 4'b0001, 1'b1);
        push0({64'h0, 64'h6000_0000_0000_0002}, 4'b0001, 1'b1);
        t0 = cyc;
        send0(64'h6000_0000_0000_0000, 1'b1);
        send0(64'h6000_0000_0000_0001, 1'b1);
        send0(64'h6000_0000_0000_0002, 1'b1);
        chk("d0_throughput", 128'(cyc - t0), 128'd3);
        s0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: frame held stable, input stalled.
        m0_ready = 1'b0;
        push0({64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}, 4'b0011, 1'b1);
        send0(64'hD0D0_D0D0_D0D0_D0D0, 1'b0);
        send0(64'hD1D1_D1D1_D1D1_D1D1, 1'b1);
        s0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", m0_valid, 1'b1);
            chk("hold_data",  m0_data,  {64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0});
            chk("hold_sready", s0_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        push0({64'hE1E1_0000_0000_0000, 64'hE0E0_0000_0000_0000}, 4'b0011, 1'b0);
        fork
            begin
                send0(64'hE0E0_0000_0000_0000, 1'b0);
                send0(64'hE1E1_0000_0000_0000, 1'b0);
                s0_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 m0_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame.
        send0(64'h4444_0000_0000_0000, 1'b0);
        s0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", m0_valid, 1'b0);
        chk("midrst_ready", s0_ready, 1'b1);
        push0({64'h5151_0000_0000_0000, 64'h5050_0000_0000_0000}, 4'b0011, 1'b1);
        send0(64'h5050_0000_0000_0000, 1'b0);
        send0(64'h5151_0000_0000_0000, 1'b1);
        s0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset drops a held output frame.
        m0_ready = 1'b0;
        send0(64'h7777_0000_0000_0000, 1'b1);
        s0_valid = 1'b0;
        chk("drop_pending", m0_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m0_ready = 1'b1;
        chk("drop_valid", m0_valid, 1'b0);
        chk("drop_data",  m0_data,  128'h0);
        repeat (2) @(posedge clk);
        #1;

        // 32-bit beats into 128-bit frames, short final frame.
        push1({32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 4'b1111, 1'b0);
        push1({64'h0, 32'hC0DE_0005, 32'hC0DE_0004}, 4'b0011, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send1(32'hC0DE_0000 | 32'(i), (i == 5));
        end
        s1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Bypass configuration is purely combinational.
        s2_data  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        s2_valid = 1'b1;
        s2_last  = 1'b1;
        m2_ready = 1'b1;
        #1;
        $display("d2 bypass data=%h", m2_data);
        chk("byp_data",  m2_data,  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("byp_valid", m2_valid, 1'b1);
        chk("byp_last",  m2_last,  1'b1);
        chk("byp_keep",  m2_keep,  1'b1);
        chk("byp_ready", s2_ready, 1'b1);
        m2_ready = 1'b0;
        s2_last  = 1'b0;
        #1;
        chk("byp_ready_low", s2_ready, 1'b0);
        chk("byp_last_low",  m2_last,  1'b0);
        s2_valid = 1'b0;
        #1;
        chk("byp_valid_low", m2_valid, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("d0_queue_empty", 128'(q0.size()), 128'd0);
        chk("d1_queue_empty", 128'(q1.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_reassembler.md
Name: packet_reassembler

Overview:
Receive-side counterpart of the transmit segmenter. Gathers narrow MTU-wide AXI-Stream beats back into full AXI_FRAME_SIZE-wide frames and restores packet boundaries on tlast. A short final frame is zero-padded, and a per-lane keep mask shows which lanes carry data. Sits between the link-receive path and the 128-bit video/RDMA datapath.

Parameters:
MTU, 64, input beat width in bits; must divide AXI_FRAME_SIZE exactly and be <= AXI_FRAME_SIZE.
AXI_FRAME_SIZE, 128, output frame width in bits.
RATIO (localparam), AXI_FRAME_SIZE/MTU, number of MTU lanes per output frame.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s_axis_tdata  in  MTU  input beat.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  block can accept an input beat.
s_axis_tlast  in  1  last beat of a packet.
m_axis_tdata  out  AXI_FRAME_SIZE  reassembled frame.
m_axis_tvalid  out  1  frame valid.
m_axis_tready  in  1  downstream accepts the frame.
m_axis_tlast  out  1  frame ends a packet.
m_axis_tkeep  out  RATIO  lane mask; bit i set = bits [i*MTU +: MTU] hold data.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Elaboration check: if AXI_FRAME_SIZE % MTU != 0, raise an assertion warning.
- MTU == AXI_FRAME_SIZE: pure combinational bypass. tdata, tvalid, tready and tlast pass straight through; m_axis_tkeep is all ones.
- Lane order: the first beat of a frame lands in lane 0 (bits [MTU-1:0]); later beats fill ascending lanes. This is the inverse of the segmenter's read order.
- Accept: a beat is accepted on s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. It does not depend on s_axis_tvalid or s_axis_tlast.
- Accumulator FSM (lane_cnt, width clog2(RATIO)):
  - ACC_IDLE (lane_cnt = 0): an accepted beat with no close condition writes lane 0 and moves to ACC_FILL.
  - ACC_FILL: each accepted beat writes lane lane_cnt and increments lane_cnt.
  - Close condition: the accepted beat is in lane RATIO-1, or it has tlast set. On close, load the output register and return to ACC_IDLE with lane_cnt = 0.
- Output register (OUT_EMPTY / OUT_FULL):
  - On close, the next cycle shows m_axis_tvalid = 1. Latency is one cycle from the closing beat.
  - m_axis_tdata holds the accumulated lanes plus the closing beat. Lanes above the closing lane are zero.
  - m_axis_tkeep = (1 << (closing_lane+1)) - 1.
  - m_axis_tlast = the closing beat's tlast.
- Stability: output fields hold steady while m_axis_tvalid && !m_axis_tready.
- Simultaneous events: in the same cycle the output frame is consumed and a new close occurs, the register reloads with no bubble. Throughput is one input beat per cycle when downstream is always ready.
- tlast in lane RATIO-1: gives a full keep mask and m_axis_tlast = 1.
- Back-to-back packets: the beat after a tlast beat always starts a new frame in lane 0.
- When m_axis_tvalid = 0: m_axis_tdata, m_axis_tkeep and m_axis_tlast are driven to 0.
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0, lane_cnt = 0, accumulator cleared, s_axis_tready = 1 after reset deasserts.
- Reset mid-operation: partial frames are discarded and the held output frame is dropped.

Optional Feature:
Macro RDMA_REASSEMBLER_STATS_EN.
- Defined: adds outputs stat_frames [31:0] (count of frames accepted downstream) and stat_packets [31:0] (count of frames accepted with tlast). Both are cleared by rst and wrap at 2^32.
- Undefined: the ports and counters are absent, with no other change.

Decomposition:
- Package rdma_stream_pkg holds:
  - gcd/lcm/ratio constant functions shared with the segmenter;
  - typedef lane_idx_t (clog2(RATIO) bits);
  - the out_state_e and acc_state_e enums.
- One sub-module, axis_hold_reg: the single-entry output register with valid/ready hold and a zero-when-invalid data mask.

Test Plan:
1. Defaults, m_axis_tready = 1. Beats A0 then A1 (tlast) -> one frame {A1,A0}, keep = 2'b11, tlast = 1, one cycle after A1 is accepted.
2. A single beat B0 with tlast -> frame {64'h0,B0}, keep = 2'b01, tlast = 1. Next beat C0 goes to lane 0.
3. Hold m_axis_tready = 0 with a frame pending -> s_axis_tready = 0, output stable. Release tready -> the next frame follows with no bubble.
4. Assert rst after one beat of a 2-beat frame -> no output frame. After reset, a fresh pair produces a correct frame.
5. MTU = 32, AXI = 128, 6 beats with tlast on the 6th -> frame 1 has keep 4'b1111, tlast = 0; frame 2 has keep 4'b0011, tlast = 1, upper 64 bits zero.
6. MTU = 128 bypass -> output equals input in the same cycle, keep = 1'b1.
